// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall and forwarding selects from in-flight register writes plus a HI/LO busy timer.
// Ports: clk, reset (async, active high); flush kills every tracked write and blocks issue;
//        d_* describe the instruction in D; stall holds F/D and bubbles E; fwd_rs/fwd_rt pick
//        the operand source (0 = register file, k+1 = tracked stage k); md_busy = HI/LO timer
//        running; stall_cnt = stall cycles since reset.
module hazard_scoreboard #(
    parameter int REGS = 32,
    parameter int DEPTH = 4,
    parameter int TW = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC = 10,
    localparam int AW = $clog2(REGS),
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_use,
    input  logic          d_md_start,
    input  logic          d_md_div,
    output logic          stall,
    output logic [SW-1:0] fwd_rs,
    output logic [SW-1:0] fwd_rt,
    output logic          md_busy,
    output logic [31:0]   stall_cnt
);
    localparam int MX = DIV_CYC > MULT_CYC ? DIV_CYC : MULT_CYC;
    localparam int CW = $clog2(MX + 1);
    logic          v_q   [DEPTH];
    logic          v_d   [DEPTH];
    logic [AW-1:0] dst_q [DEPTH];
    logic [AW-1:0] dst_d [DEPTH];
    logic [TW-1:0] rem_q [DEPTH];
    logic [TW-1:0] rem_d [DEPTH];
    logic [CW-1:0] md_q, md_d;
    logic [31:0]   cnt_q;
    logic          rs_hit, rt_hit, issue;
    logic [TW-1:0] rs_rem, rt_rem;
    logic [SW-1:0] rs_idx, rt_idx;
    // Walk oldest to youngest so the youngest matching entry is the one left standing.
    always_comb begin
        rs_hit = 1'b0;
        rs_rem = '0;
        rs_idx = '0;
        rt_hit = 1'b0;
        rt_rem = '0;
        rt_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (v_q[k] && dst_q[k] == d_rs && d_rs != '0) begin
                rs_hit = 1'b1;
                rs_rem = rem_q[k];
                rs_idx = SW'(k + 1);
            end
            if (v_q[k] && dst_q[k] == d_rt && d_rt != '0) begin
                rt_hit = 1'b1;
                rt_rem = rem_q[k];
                rt_idx = SW'(k + 1);
            end
        end
    end
    assign md_busy   = md_q != '0;
    assign stall     = d_valid & ((rs_hit & (rs_rem > d_tuse_rs)) | (rt_hit & (rt_rem > d_tuse_rt)) | (d_md_use & md_busy));
    assign fwd_rs    = rs_hit && rs_rem == '0 ? rs_idx : '0;
    assign fwd_rt    = rt_hit && rt_rem == '0 ? rt_idx : '0;
    assign issue     = d_valid & ~stall & ~flush;
    assign stall_cnt = cnt_q;
    // The pipe shifts every cycle; a non-issuing cycle inserts a bubble at entry 0.
    always_comb begin
        v_d[0]   = issue;
        dst_d[0] = issue ? d_dst : '0;
        rem_d[0] = issue && d_tnew != '0 ? d_tnew - TW'(1) : '0;
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]   = v_q[k-1] & ~flush;
            dst_d[k] = dst_q[k-1];
            rem_d[k] = rem_q[k-1] != '0 ? rem_q[k-1] - TW'(1) : '0;
        end
        md_d = issue && d_md_start ? (d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC))
             : md_q != '0 ? md_q - CW'(1) : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k]   <= 1'b0;
                dst_q[k] <= '0;
                rem_q[k] <= '0;
            end
            md_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                v_q[k]   <= v_d[k];
                dst_q[k] <= dst_d[k];
                rem_q[k] <= rem_d[k];
            end
            md_q  <= md_d;
            cnt_q <= cnt_q + {31'd0, stall};
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios plus random traffic against a time-based hazard model.
module tb_hazard_scoreboard;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        reset, flush, d_valid;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [2:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_md_use, d_md_start, d_md_div;
    logic        stall, md_busy;
    logic [2:0]  fwd_rs, fwd_rt;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_use(d_md_use), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    // A producer is remembered by the edge at which it issued; its stage and
    // remaining latency follow from elapsed time.
    typedef struct {int dst; int tnew; int at;} prod_t;
    prod_t      q[$];
    int         now, flush_at, md_at, md_n, cnt_exp, n_vec, n_err, n;
    logic       obs_st;
    logic [2:0] obs_frs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void lookup(input int s, output int fwd, output int rem, output bit hit);
        int bk;
        bk = DEPTH;
        hit = 0;
        rem = 0;
        for (int i = 0; i < q.size(); i++) begin
            int k;
            k = now - q[i].at;
            if (s != 0 && q[i].dst == s && k >= 0 && k < DEPTH && q[i].at > flush_at && k < bk) begin
                hit = 1;
                bk = k;
                rem = q[i].tnew - 1 - k > 0 ? q[i].tnew - 1 - k : 0;
            end
        end
        fwd = hit && rem == 0 ? bk + 1 : 0;
    endfunction

    task automatic model_reset;
        q.delete();
        now = 0;
        flush_at = -1;
        md_at = 0;
        md_n = 0;
        cnt_exp = 0;
    endtask

    task automatic drive(input bit v, input int rs, rt, tr, tt, dst, tn, input bit mu, ms, md, fl);
        d_valid = v;
        d_rs = 5'(rs);
        d_rt = 5'(rt);
        d_tuse_rs = 3'(tr);
        d_tuse_rt = 3'(tt);
        d_dst = 5'(dst);
        d_tnew = 3'(tn);
        d_md_use = mu | ms;
        d_md_start = ms;
        d_md_div = md;
        flush = fl;
    endtask

    task automatic step(input bit v, input int rs, rt, tr, tt, dst, tn, input bit mu, ms, md, fl);
        bit hs, ht, e_busy, e_st;
        int frs, frt, rrs, rrt;
        @(negedge clk);
        drive(v, rs, rt, tr, tt, dst, tn, mu, ms, md, fl);
        #1;
        lookup(rs, frs, rrs, hs);
        lookup(rt, frt, rrt, ht);
        e_busy = (now - md_at) < md_n;
        e_st = v && ((hs && rrs > tr) || (ht && rrt > tt) || ((mu || ms) && e_busy));
        chk("stall", {31'd0, stall}, {31'd0, e_st});
        chk("fwd_rs", {29'd0, fwd_rs}, frs);
        chk("fwd_rt", {29'd0, fwd_rt}, frt);
        chk("md_busy", {31'd0, md_busy}, {31'd0, e_busy});
        chk("stall_cnt", stall_cnt, cnt_exp);
        obs_st = stall;
        obs_frs = fwd_rs;
        @(posedge clk);
        if (v && !e_st && !fl) begin
            q.push_back('{dst, tn, now + 1});
            if (ms) begin
                md_at = now + 1;
                md_n = md ? 10 : 5;
            end
        end
        if (fl) flush_at = now + 1;
        cnt_exp += e_st ? 1 : 0;
        now++;
        while (q.size() > 0 && now - q[0].at >= DEPTH) void'(q.pop_front());
    endtask

    task automatic nop;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Re-presents one consumer until the DUT lets it issue; n is the stall cycles seen.
    task automatic until_issue(input int rs, rt, tr, tt, dst, tn, input bit mu, output int cnt);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, rs, rt, tr, tt, dst, tn, mu, 0, 0, 0);
            if (!obs_st) break;
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        reset = 1'b1;
        drive(1, 3, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        #2;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_busy", {31'd0, md_busy}, 0);
        chk("rst_fwd", {29'd0, fwd_rs}, 0);
        chk("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        // ALU result feeding a branch
        step(1, 1, 2, 1, 1, 3, 2, 0, 0, 0, 0);
        until_issue(3, 0, 0, 0, 0, 0, 0, n);
        chk("br_stalls", n, 1);
        chk("br_fwd", {29'd0, obs_frs}, 2);
        chk("br_cnt", stall_cnt, 1);
        // load-use
        step(1, 1, 0, 1, 4, 5, 4, 0, 0, 0, 0);
        until_issue(5, 5, 1, 1, 6, 2, 0, n);
        chk("lu_stalls", n, 2);
        chk("lu_fwd", {29'd0, obs_frs}, 0);
        // multiply then divide against HI/LO readers
        step(1, 1, 2, 1, 1, 0, 0, 1, 1, 0, 0);
        until_issue(0, 0, 0, 0, 8, 2, 1, n);
        chk("mult_stalls", n, 5);
        step(1, 1, 2, 1, 1, 0, 0, 1, 1, 1, 0);
        until_issue(0, 0, 0, 0, 9, 2, 1, n);
        chk("div_stalls", n, 10);
        // youngest writer wins even when an older one is ready
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        nop();
        nop();
        step(1, 0, 0, 0, 0, 7, 2, 0, 0, 0, 0);
        step(1, 7, 0, 2, 4, 10, 2, 0, 0, 0, 0);
        chk("pri_stall", {31'd0, obs_st}, 0);
        chk("pri_fwd", {29'd0, obs_frs}, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 11, 2, 0, 0, 0, 0);
        chk("r0_fwd", {29'd0, obs_frs}, 0);
        // flush kills tracked writes, not the HI/LO timer
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 5, 4, 0, 0, 0, 0);
        step(1, 5, 0, 1, 1, 6, 2, 0, 0, 0, 0);
        chk("fl_pre_stall", {31'd0, obs_st}, 1);
        step(1, 5, 0, 1, 1, 6, 2, 0, 0, 0, 1);
        step(1, 5, 0, 1, 1, 6, 2, 0, 0, 0, 0);
        chk("fl_stall", {31'd0, obs_st}, 0);
        chk("fl_fwd", {29'd0, obs_frs}, 0);
        chk("fl_busy", {31'd0, md_busy}, 1);
        // asynchronous reset in the middle of a divide
        step(1, 0, 0, 0, 0, 9, 4, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        @(negedge clk);
        drive(1, 9, 0, 0, 0, 12, 2, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_busy", {31'd0, md_busy}, 0);
        chk("mid_stall", {31'd0, stall}, 0);
        chk("mid_cnt", stall_cnt, 0);
        chk("mid_fwd", {29'd0, fwd_rs}, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1, 0, 0, 0, 0, 12, 2, 1, 0, 0, 0);
        chk("post_mflo", {31'd0, obs_st}, 0);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit ms, mu;
            ms = $urandom_range(0, 11) == 0;
            mu = ms | ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 6) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 7),
                 $urandom_range(0, 4), mu, ms, $urandom_range(0, 1), $urandom_range(0, 39) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
